// File: rtl/pipelined_addsub_unit.sv
// Digit-serial two's-complement adder/subtractor with valid/ready handshakes.
// Define ADDSUB_SAT_EN to saturate the result on signed overflow instead of wrapping.
module pipelined_addsub_unit #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             c_out,
  output logic             ovf
);

  localparam int K     = WIDTH / DIGIT;
  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] r_r;
  logic [CNT_W-1:0] count_r;
  logic             carry_r;
  logic             c_out_r;
  logic             ovf_r;
  logic             out_valid_r;
  logic             in_ready_r;

  logic [DIGIT-1:0] a_dig_s;
  logic [DIGIT-1:0] b_dig_s;
  logic [DIGIT:0]   sum_s;
  logic             c_msb_in_s;
  logic             ovf_s;
  logic             last_s;
  logic [WIDTH-1:0] r_dig_s;
  logic [WIDTH-1:0] r_next_s;

  // Current digit slice, its sum, and the flags produced when it is the top digit.
  always_comb begin
    a_dig_s    = DIGIT'(a_r >> (DIGIT * int'(count_r)));
    b_dig_s    = DIGIT'(b_r >> (DIGIT * int'(count_r)));
    sum_s      = {1'b0, a_dig_s} + {1'b0, b_dig_s} + {{DIGIT{1'b0}}, carry_r};
    // Carry into a bit equals sum ^ a ^ b at that bit; works for DIGIT == 1 too.
    c_msb_in_s = sum_s[DIGIT-1] ^ a_dig_s[DIGIT-1] ^ b_dig_s[DIGIT-1];
    ovf_s      = c_msb_in_s ^ sum_s[DIGIT];
    last_s     = (count_r == CNT_W'(K - 1));
    // Unwritten digits are zero, so OR-ing the new digit in place is sufficient.
    r_dig_s    = r_r | (WIDTH'(sum_s[DIGIT-1:0]) << (DIGIT * int'(count_r)));
`ifdef ADDSUB_SAT_EN
    r_next_s   = (last_s && ovf_s)
               ? (a_r[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}})
               : r_dig_s;
`else
    r_next_s   = r_dig_s;
`endif
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      r_r         <= {WIDTH{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      carry_r     <= 1'b0;
      c_out_r     <= 1'b0;
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready_r) begin
            a_r        <= a;
            b_r        <= b ^ {WIDTH{sub}};
            carry_r    <= sub;
            count_r    <= {CNT_W{1'b0}};
            r_r        <= {WIDTH{1'b0}};
            c_out_r    <= 1'b0;
            ovf_r      <= 1'b0;
            in_ready_r <= 1'b0;
            state_r    <= RUN;
          end
        end
        RUN: begin
          r_r     <= r_next_s;
          carry_r <= sum_s[DIGIT];
          count_r <= count_r + CNT_W'(1);
          if (last_s) begin
            c_out_r     <= sum_s[DIGIT];
            ovf_r       <= ovf_s;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign r         = r_r;
  assign c_out     = c_out_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_pipelined_addsub_unit.sv
// Self-checking bench: WIDTH=8/DIGIT=4 and WIDTH=16/DIGIT=1 instances against an arithmetic model.
module tb_pipelined_addsub_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a;
  logic [15:0] b;
  logic        sub;
  logic        out_ready;
  logic        in_valid0;
  logic        in_valid1;

  logic        in_ready0, out_valid0, c0, ovf0;
  logic [7:0]  r0;
  logic        in_ready1, out_valid1, c1, ovf1;
  logic [15:0] r1;

  int tests = 0;
  int fails = 0;
  int cur   = 0;

  logic        in_ready_c, out_valid_c, c_c, ovf_c;
  logic [15:0] r_c;

  always #5 clk = ~clk;

  pipelined_addsub_unit #(.WIDTH(8), .DIGIT(4)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
    .a(a[7:0]), .b(b[7:0]), .sub(sub), .out_valid(out_valid0),
    .out_ready(out_ready), .r(r0), .c_out(c0), .ovf(ovf0)
  );

  pipelined_addsub_unit #(.WIDTH(16), .DIGIT(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid1),
    .out_ready(out_ready), .r(r1), .c_out(c1), .ovf(ovf1)
  );

  assign in_ready_c  = (cur == 1) ? in_ready1  : in_ready0;
  assign out_valid_c = (cur == 1) ? out_valid1 : out_valid0;
  assign c_c         = (cur == 1) ? c1         : c0;
  assign ovf_c       = (cur == 1) ? ovf1       : ovf0;
  assign r_c         = (cur == 1) ? r1         : {8'h00, r0};

  // Returns {ovf, c_out, r} from plain signed/unsigned arithmetic.
  function automatic logic [17:0] model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                        input logic s);
    longint unsigned m, half, ua, ub, ures;
    longint sa, sb, sres;
    logic o, c;
    logic [15:0] rr;
    m    = 64'd1 << w;
    half = m >> 1;
    ua   = {48'd0, av} % m;
    ub   = {48'd0, bv} % m;
    sa   = (ua >= half) ? longint'(ua) - longint'(m) : longint'(ua);
    sb   = (ub >= half) ? longint'(ub) - longint'(m) : longint'(ub);
    sres = s ? sa - sb : sa + sb;
    o    = (sres >= longint'(half)) || (sres < -longint'(half));
    ures = s ? ua + m - ub : ua + ub;
    c    = (ures >= m);
    rr   = 16'(ures % m);
`ifdef ADDSUB_SAT_EN
    if (o) rr = (ua >= half) ? 16'(half) : 16'(half - 64'd1);
`endif
    return {o, c, rr};
  endfunction

  task automatic run_op(input int sel, input logic [15:0] av, input logic [15:0] bv,
                        input logic s, input int hold);
    logic [17:0] exp;
    int k, cyc;
    k   = (sel == 1) ? 16 : 2;
    exp = model((sel == 1) ? 16 : 8, av, bv, s);
    @(negedge clk);
    cur = sel; a = av; b = bv; sub = s; out_ready = 1'b0;
    if (sel == 1) in_valid1 = 1'b1; else in_valid0 = 1'b1;
    tests++;
    if (in_ready_c !== 1'b1) begin fails++; $display("FAIL idle_in_ready: got %b expected 1", in_ready_c); end
    @(posedge clk); #1;
    in_valid0 = 1'b0; in_valid1 = 1'b0;
    a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
    tests++;
    if (in_ready_c !== 1'b0) begin fails++; $display("FAIL run_in_ready: got %b expected 0", in_ready_c); end
    cyc = 0;
    while (out_valid_c !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1; cyc++;
    end
    tests++;
    if (cyc !== k) begin fails++; $display("FAIL latency: got %0d cycles expected %0d", cyc, k); end
    tests++;
    if ({ovf_c, c_c, r_c} !== exp)
      begin fails++; $display("FAIL result a=%h b=%h sub=%b: got ovf=%b c=%b r=%h expected ovf=%b c=%b r=%h",
                              av, bv, s, ovf_c, c_c, r_c, exp[17], exp[16], exp[15:0]); end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      tests++;
      if (out_valid_c !== 1'b1 || in_ready_c !== 1'b0 || {ovf_c, c_c, r_c} !== exp)
        begin fails++; $display("FAIL hold cycle %0d: got v=%b rdy=%b ovf=%b c=%b r=%h expected v=1 rdy=0 %h",
                                i, out_valid_c, in_ready_c, ovf_c, c_c, r_c, exp); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests++;
    if (out_valid_c !== 1'b0 || in_ready_c !== 1'b1)
      begin fails++; $display("FAIL release: got v=%b rdy=%b expected v=0 rdy=1", out_valid_c, in_ready_c); end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid0 = 1'b0; in_valid1 = 1'b0; out_ready = 1'b0;
    a = 16'd0; b = 16'd0; sub = 1'b0;
    #2;
    tests++;
    if ({in_ready0, out_valid0, c0, ovf0, r0} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00} ||
        {in_ready1, out_valid1, c1, ovf1, r1} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000})
      begin fails++; $display("FAIL reset_state: got %b%b%b%b %h / %b%b%b%b %h expected 1000 00 / 1000 0000",
                              in_ready0, out_valid0, c0, ovf0, r0, in_ready1, out_valid1, c1, ovf1, r1); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    run_op(0, 16'd100, 16'd27, 1'b0, 0);
    run_op(0, 16'd5,   16'd3,  1'b1, 0);
    run_op(0, 16'd3,   16'd5,  1'b1, 0);
    run_op(0, 16'd127, 16'd1,  1'b0, 0);
    run_op(0, 16'd128, 16'd1,  1'b1, 0);
    run_op(1, 16'h7FFF, 16'h0001, 1'b0, 0);
    run_op(1, 16'h8000, 16'h0001, 1'b1, 0);
  endtask

  task automatic test_backpressure();
    run_op(0, 16'd90, 16'd77, 1'b0, 5);
    run_op(0, 16'd200, 16'd100, 1'b1, 0);
  endtask

  task automatic test_reset_mid(input int sel, input int run_cycles);
    @(negedge clk);
    cur = sel; a = 16'h0007; b = 16'h0000; sub = 1'b0;
    if (sel == 1) in_valid1 = 1'b1; else in_valid0 = 1'b1;
    @(posedge clk); #1;
    in_valid0 = 1'b0; in_valid1 = 1'b0;
    for (int i = 0; i < run_cycles; i++) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    tests++;
    if ({in_ready_c, out_valid_c, c_c, ovf_c, r_c} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000})
      begin fails++; $display("FAIL reset_mid: got rdy=%b v=%b c=%b ovf=%b r=%h expected 1 0 0 0 0000",
                              in_ready_c, out_valid_c, c_c, ovf_c, r_c); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    run_op(sel, 16'd15, 16'd15, 1'b1, 0);
  endtask

  task automatic test_random();
    int sel;
    logic [15:0] av, bv;
    for (int n = 0; n < 30; n++) begin
      sel = int'($urandom_range(1, 0));
      av  = 16'($urandom);
      bv  = 16'($urandom);
      if (sel == 0) begin av[15:8] = 8'h00; bv[15:8] = 8'h00; end
      run_op(sel, av, bv, 1'($urandom), int'($urandom_range(3, 0)));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid(0, 0);
    test_reset_mid(1, 3);
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
